// File: rtl/calc_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer_if
// Handshake/operand bundle between the calculator state controller (master)
// and the multi-cycle arithmetic sequencer (slave).
//   i_start       one-cycle start pulse
//   i_arith_func  00 add, 01 sub, 10 mul, 11 div
//   i_s1/i_sign1  operand 1 magnitude / sign (1 = negative)
//   i_s2/i_sign2  operand 2 magnitude / sign
//   o_busy        operation in progress
//   o_done        one-cycle result-valid pulse
//   o_result      result magnitude, held until the next accepted start
//   o_sign        result sign
//   o_err         overflow or divide-by-zero
//   o_state       current sequencer state, for LED debug
// ---------------------------------------------------------------------------
interface calc_op_sequencer_if #(
  parameter int WIDTH = 40
);
  logic             i_start;
  logic [1:0]       i_arith_func;
  logic [WIDTH-1:0] i_s1;
  logic             i_sign1;
  logic [WIDTH-1:0] i_s2;
  logic             i_sign2;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_sign;
  logic             o_err;
  logic [2:0]       o_state;

  modport master (
    output i_start, i_arith_func, i_s1, i_sign1, i_s2, i_sign2,
    input  o_busy, o_done, o_result, o_sign, o_err, o_state
  );

  modport slave (
    input  i_start, i_arith_func, i_s1, i_sign1, i_s2, i_sign2,
    output o_busy, o_done, o_result, o_sign, o_err, o_state
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
// Multi-cycle sign-magnitude arithmetic for the calculator. One shared
// adder/subtractor is sequenced through a single-pass add/sub, an MSB-first
// shift-add multiply, or an MSB-first restoring divide.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high reset
//   bus      calc_op_sequencer_if.slave (start/operands in, result/status out)
//
// state  | code | meaning
// -------+------+-----------------------------------------------------------
// IDLE   |  0   | waiting for i_start; operands latched when it arrives
// LOAD   |  1   | fix sub sign, clear accumulator/counter, pick datapath
// ADDSUB |  2   | single signed-magnitude add/subtract
// MUL    |  3   | ITER shift-add steps, then one cycle moving product to mag
// DIV    |  4   | ITER restoring steps, then one cycle moving quotient to mag
// CHECK  |  5   | range/div-by-zero check, register visible result
// DONE   |  6   | o_done pulse, back to IDLE
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int WIDTH   = 40,
  parameter int ITER    = 20,
  parameter int MAX_VAL = 999999
) (
  input logic                i_clk,
  input logic                i_reset,
  calc_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ADDSUB = 3'd2,
    S_MUL    = 3'd3,
    S_DIV    = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int               CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ITER - 1);
  localparam logic [WIDTH-1:0] MAX_MAG = WIDTH'(MAX_VAL);
  localparam logic [1:0]       F_SUB   = 2'b01;
  localparam logic [1:0]       F_DIV   = 2'b11;

  state_t            state, state_nxt;
  logic [ITER-1:0]   a_l, b_l;
  logic              sign1_l, sign2_l;
  logic [1:0]        func_l;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  mag;
  logic              res_sign;
  logic              err_l;
  logic [CNT_W-1:0]  cnt;
  logic              drain;

  // Only the low ITER operand bits take part; the rest are intentionally dropped.
  logic unused_upper;
  assign unused_upper = ^{bus.i_s1[WIDTH-1:ITER], bus.i_s2[WIDTH-1:ITER]};

  logic [WIDTH-1:0] a_ext, b_ext;
  logic             a_ge_b;
  logic [WIDTH-1:0] mul_shift, div_shift;
  assign a_ext     = {{(WIDTH-ITER){1'b0}}, a_l};
  assign b_ext     = {{(WIDTH-ITER){1'b0}}, b_l};
  assign a_ge_b    = (a_l >= b_l);
  assign mul_shift = {acc[WIDTH-2:0], 1'b0};
  assign div_shift = {rem[WIDTH-2:0], a_l[cnt]};

  // Shared adder/subtractor. With add_sub set, add_sum[WIDTH] is the
  // no-borrow flag (add_x >= add_y), which the divider uses as its quotient bit.
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  assign add_sum = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
                 + {{WIDTH{1'b0}}, add_sub};

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (state)
      S_ADDSUB: begin
        if (sign1_l == sign2_l) begin
          add_x = a_ext;
          add_y = b_ext;
        end else if (a_ge_b) begin
          add_x   = a_ext;
          add_y   = b_ext;
          add_sub = 1'b1;
        end else begin
          add_x   = b_ext;
          add_y   = a_ext;
          add_sub = 1'b1;
        end
      end
      S_MUL: begin
        add_x = mul_shift;
        add_y = b_l[cnt] ? a_ext : '0;
      end
      S_DIV: begin
        add_x   = div_shift;
        add_y   = b_ext;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    bus.o_busy = 1'b0;
    bus.o_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.o_busy = 1'b1;
        case (func_l)
          2'b10:   state_nxt = S_MUL;
          2'b11:   state_nxt = (b_l == '0) ? S_CHECK : S_DIV;
          default: state_nxt = S_ADDSUB;
        endcase
      end
      S_ADDSUB: begin
        bus.o_busy = 1'b1;
        state_nxt  = S_CHECK;
      end
      S_MUL, S_DIV: begin
        bus.o_busy = 1'b1;
        if (drain) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        bus.o_busy = 1'b1;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.o_state = state;

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_l          <= '0;
      b_l          <= '0;
      sign1_l      <= 1'b0;
      sign2_l      <= 1'b0;
      func_l       <= 2'b00;
      acc          <= '0;
      rem          <= '0;
      mag          <= '0;
      res_sign     <= 1'b0;
      err_l        <= 1'b0;
      cnt          <= '0;
      drain        <= 1'b0;
      bus.o_result <= '0;
      bus.o_sign   <= 1'b0;
      bus.o_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            a_l     <= bus.i_s1[ITER-1:0];
            b_l     <= bus.i_s2[ITER-1:0];
            sign1_l <= bus.i_sign1;
            sign2_l <= bus.i_sign2;
            func_l  <= bus.i_arith_func;
          end
        end
        S_LOAD: begin
          // Subtraction is an add of the negated second operand.
          if (func_l == F_SUB) sign2_l <= ~sign2_l;
          acc      <= '0;
          rem      <= '0;
          mag      <= '0;
          cnt      <= CNT_TOP;
          drain    <= 1'b0;
          err_l    <= (func_l == F_DIV) && (b_l == '0);
          res_sign <= sign1_l ^ sign2_l;
        end
        S_ADDSUB: begin
          mag <= add_sum[WIDTH-1:0];
          if (sign1_l == sign2_l) res_sign <= sign1_l;
          else                    res_sign <= a_ge_b ? sign1_l : sign2_l;
        end
        S_MUL: begin
          if (!drain) begin
            acc <= add_sum[WIDTH-1:0];
            if (cnt == '0) drain <= 1'b1;
            else           cnt   <= cnt - 1'b1;
          end else begin
            mag <= acc;
          end
        end
        S_DIV: begin
          if (!drain) begin
            rem <= add_sum[WIDTH] ? add_sum[WIDTH-1:0] : div_shift;
            acc <= {acc[WIDTH-2:0], add_sum[WIDTH]};
            if (cnt == '0) drain <= 1'b1;
            else           cnt   <= cnt - 1'b1;
          end else begin
            mag <= acc;
          end
        end
        S_CHECK: begin
          if (err_l || (mag > MAX_MAG)) begin
            bus.o_result <= '0;
            bus.o_sign   <= 1'b0;
            bus.o_err    <= 1'b1;
          end else begin
            bus.o_result <= mag;
            bus.o_sign   <= res_sign && (mag != '0);
            bus.o_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;
  localparam int     WIDTH   = 40;
  localparam int     ITER    = 20;
  localparam longint MAX_VAL = 999999;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;

  calc_op_sequencer_if #(.WIDTH(WIDTH)) bus();

  calc_op_sequencer #(.WIDTH(WIDTH), .ITER(ITER), .MAX_VAL(999999)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: signed arithmetic on the masked operands, then range rules.
  function automatic void model(input logic [1:0] f, input logic [WIDTH-1:0] s1,
                                input logic sg1, input logic [WIDTH-1:0] s2,
                                input logic sg2, output logic [WIDTH-1:0] r,
                                output logic s, output logic e, output int lat);
    longint mask, a, b, va, vb, t, mag;
    logic   neg;
    mask = (longint'(1) << ITER) - 1;
    a    = longint'(s1) & mask;
    b    = longint'(s2) & mask;
    e    = 1'b0;
    lat  = 3;
    mag  = 0;
    neg  = 1'b0;
    case (f)
      2'b00, 2'b01: begin
        va = sg1 ? -a : a;
        vb = sg2 ? -b : b;
        if (f == 2'b01) vb = -vb;
        t   = va + vb;
        neg = (t < 0);
        mag = neg ? -t : t;
      end
      2'b10: begin
        mag = a * b;
        neg = sg1 ^ sg2;
        lat = ITER + 3;
      end
      default: begin
        neg = sg1 ^ sg2;
        if (b == 0) begin
          e   = 1'b1;
          lat = 2;
        end else begin
          mag = a / b;
          lat = ITER + 3;
        end
      end
    endcase
    if (e || mag > MAX_VAL) begin
      r = '0;
      s = 1'b0;
      e = 1'b1;
    end else begin
      r = WIDTH'(mag);
      s = (mag == 0) ? 1'b0 : neg;
    end
  endfunction

  // Issues one op (start sampled at "edge 0"), scrambles inputs afterwards,
  // optionally pulses a second start at edge inject_at, and optionally holds
  // start high during the DONE cycle. Returns one cycle after DONE.
  task automatic run_op(input string name, input logic [1:0] f,
                        input logic [WIDTH-1:0] s1, input logic sg1,
                        input logic [WIDTH-1:0] s2, input logic sg2,
                        input int inject_at, input bit start_in_done);
    logic [WIDTH-1:0] er;
    logic             es, ee;
    int               lat, n, busy_cnt;
    bit               got;
    model(f, s1, sg1, s2, sg2, er, es, ee, lat);
    bus.i_arith_func = f;
    bus.i_s1         = s1;
    bus.i_sign1      = sg1;
    bus.i_s2         = s2;
    bus.i_sign2      = sg2;
    bus.i_start      = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start      = 1'b0;
    bus.i_s1         = WIDTH'({$urandom(), $urandom()});
    bus.i_s2         = WIDTH'({$urandom(), $urandom()});
    bus.i_sign1      = ~sg1;
    bus.i_sign2      = ~sg2;
    bus.i_arith_func = ~f;
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_at_edge0 got %b want 1", name, bus.o_busy);
    end
    n = 0;
    busy_cnt = 0;
    got = 0;
    while (n < 60 && !got) begin
      bus.i_start = (n + 1 == inject_at);
      if (bus.o_busy) busy_cnt++;
      @(posedge i_clk); #1;
      n++;
      if (bus.o_done) got = 1;
    end
    bus.i_start = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s done_timeout got no done in %0d cycles want done after edge %0d", name, n, lat);
    end else begin
      n_checks += 6;
      if (n !== lat) begin
        n_fail++;
        $display("FAIL %s latency got edge %0d want edge %0d", name, n, lat);
      end
      if (busy_cnt !== lat) begin
        n_fail++;
        $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, lat);
      end
      if (bus.o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_in_done got %b want 0", name, bus.o_busy);
      end
      if (bus.o_result !== er) begin
        n_fail++;
        $display("FAIL %s result got %0d want %0d", name, bus.o_result, er);
      end
      if (bus.o_sign !== es) begin
        n_fail++;
        $display("FAIL %s sign got %b want %b", name, bus.o_sign, es);
      end
      if (bus.o_err !== ee) begin
        n_fail++;
        $display("FAIL %s err got %b want %b", name, bus.o_err, ee);
      end
    end
    if (start_in_done) bus.i_start = 1'b1;
    @(posedge i_clk); #1;
    n_checks += 3;
    if (bus.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width got %b want 0", name, bus.o_done);
    end
    if (bus.o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL %s state_after_done got %0d want 0", name, bus.o_state);
    end
    if (bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_done got %b want 0", name, bus.o_busy);
    end
    if (got && bus.o_result !== er) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s result_hold got %0d want %0d", name, bus.o_result, er);
    end
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.i_arith_func = 2'b00;
    bus.i_s1 = '0; bus.i_s2 = '0; bus.i_sign1 = 1'b0; bus.i_sign2 = 1'b0;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks += 6;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    if (bus.o_result !== '0) begin n_fail++; $display("FAIL reset_result got %0d want 0", bus.o_result); end
    if (bus.o_sign !== 1'b0) begin n_fail++; $display("FAIL reset_sign got %b want 0", bus.o_sign); end
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.o_err); end
    if (bus.o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.o_state); end
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_directed();
    run_op("add_opp",   2'b00, 40'd25,     1'b0, 40'd40,   1'b1, -1, 0);
    run_op("mul_999k",  2'b10, 40'd999,    1'b0, 40'd1000, 1'b1, -1, 0);
    run_op("mul_ovf",   2'b10, 40'd1000,   1'b0, 40'd1000, 1'b0, -1, 0);
    run_op("div_7_2",   2'b11, 40'd7,      1'b0, 40'd2,    1'b1, -1, 0);
    run_op("div_zero_n",2'b11, 40'd0,      1'b1, 40'd5,    1'b0, -1, 0);
    run_op("div_by_0",  2'b11, 40'd12,     1'b0, 40'd0,    1'b0, -1, 0);
    run_op("sub_zero",  2'b01, 40'd500,    1'b0, 40'd500,  1'b0, -1, 0);
    run_op("add_ovf",   2'b00, 40'd999999, 1'b0, 40'd1,    1'b0, -1, 0);
    run_op("sub_neg",   2'b01, 40'd3,      1'b1, 40'd10,   1'b1, -1, 0);
    run_op("upper_ign", 2'b00, 40'hAB_0000_0005, 1'b0, 40'h12_0000_0007, 1'b1, -1, 0);
  endtask

  task automatic test_random();
    logic [1:0]       f;
    logic [WIDTH-1:0] s1, s2;
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin s1 = WIDTH'({$urandom(), $urandom()}); s2 = WIDTH'({$urandom(), $urandom()}); end
        1: begin s1 = WIDTH'($urandom_range(0, 1500)); s2 = WIDTH'($urandom_range(0, 1500)); end
        default: begin s1 = WIDTH'($urandom_range(0, 999999)); s2 = WIDTH'($urandom_range(0, 40)); end
      endcase
      run_op("random", f, s1, 1'($urandom()), s2, 1'($urandom()), -1, 0);
    end
  endtask

  task automatic test_start_while_busy();
    run_op("div_busy", 2'b11, 40'd7, 1'b0, 40'd2, 1'b1, 5, 1);
    run_op("back_to_back", 2'b00, 40'd123, 1'b0, 40'd456, 1'b0, -1, 0);
  endtask

  task automatic test_reset_mid_mul();
    int dones;
    bus.i_arith_func = 2'b10;
    bus.i_s1 = 40'd300; bus.i_sign1 = 1'b1;
    bus.i_s2 = 40'd200; bus.i_sign2 = 1'b0;
    bus.i_start = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    n_checks += 6;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", bus.o_busy); end
    if (bus.o_state !== 3'd0) begin n_fail++; $display("FAIL mid_reset_state got %0d want 0", bus.o_state); end
    if (bus.o_result !== '0) begin n_fail++; $display("FAIL mid_reset_result got %0d want 0", bus.o_result); end
    if (bus.o_sign !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sign got %b want 0", bus.o_sign); end
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_err got %b want 0", bus.o_err); end
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got %b want 0", bus.o_done); end
    i_reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (bus.o_done) dones++;
    end
    n_checks += 2;
    if (dones !== 0) begin n_fail++; $display("FAIL mid_reset_no_done got %0d pulses want 0", dones); end
    if (bus.o_state !== 3'd0) begin n_fail++; $display("FAIL mid_reset_idle got %0d want 0", bus.o_state); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Multi-cycle arithmetic sequencer for the basic calculator. It accepts a start pulse plus two sign-magnitude operands and an operation code, then sequences one shared adder/subtractor through the operation: single pass for add/sub, iterative shift-add for multiply, restoring division for divide. It sits between the state controller (operand/sign source) and the digit separator (result/sign/error sink). It replaces the combinational calculate path with a start/busy/done handshake.

Parameters:
WIDTH, 40, operand/result magnitude width (matches 40-bit calculator buses)
ITER, 20, operand bits used by mul/div and iteration count; 2^ITER-1 >= MAX_VAL
MAX_VAL, 999999, largest displayable magnitude (six 7-seg digits); above this is overflow

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle start pulse (from pulse generator); honoured only in IDLE
i_arith_func  in  2  00 add, 01 sub, 10 mul, 11 div; latched at start
i_s1  in  WIDTH  operand 1 magnitude
i_sign1  in  1  operand 1 sign (1 = negative)
i_s2  in  WIDTH  operand 2 magnitude
i_sign2  in  1  operand 2 sign
o_busy  out  1  operation in progress
o_done  out  1  one-cycle pulse, result valid
o_result  out  WIDTH  result magnitude, held until next accepted start
o_sign  out  1  result sign
o_err  out  1  overflow or divide-by-zero, held with result
o_state  out  3  current FSM state, for LED debug

Behaviour:
- Reset (sync, high): state IDLE; o_busy=0, o_done=0, o_result=0, o_sign=0, o_err=0; iteration counter=0. Wins over everything, including mid-operation; an aborted operation produces no o_done.
- States (o_state encoding): IDLE=0, LOAD=1, ADDSUB=2, MUL=3, DIV=4, CHECK=5, DONE=6.
- IDLE: on i_start=1, latch i_s1[ITER-1:0], i_s2[ITER-1:0], signs and func; o_busy<=1; go to LOAD. Upper operand bits are ignored.
- LOAD: for sub, invert latched sign2. Clear accumulator, clear counter (ITER-1 down to 0). Then:
  - add/sub -> ADDSUB
  - mul -> MUL
  - div with divisor 0 -> CHECK with err flag set
  - div otherwise -> DIV
- ADDSUB (1 cycle):
  - Signs equal: mag = a+b, sign = sign1.
  - Signs differ: mag = |a-b|, sign = sign of the larger magnitude.
  - Go to CHECK.
- MUL (ITER cycles): each cycle, if multiplier bit[counter] is set, acc = (acc<<1)+a, else acc = acc<<1. Processed MSB first. Uses the shared adder. After counter 0 -> CHECK. sign = sign1^sign2.
- DIV (ITER cycles): restoring division, MSB first.
  - rem = (rem<<1)|dividend bit.
  - If rem >= b, then rem -= b and the quotient bit is 1.
  - Quotient truncates toward zero; remainder is discarded. sign = sign1^sign2.
- CHECK (1 cycle):
  - If err (div-by-0) or mag > MAX_VAL: o_result<=0, o_sign<=0, o_err<=1.
  - Otherwise o_result<=mag, o_err<=0, o_sign<=sign; sign is forced to 0 when mag==0 (no negative zero).
  - Go to DONE.
- DONE (1 cycle): o_done=1, o_busy=0; next state IDLE.
- Latency: the edge sampling i_start is edge 0.
  - add/sub: o_done high in the cycle after edge 3.
  - mul/div: o_done high in the cycle after edge ITER+3 (23 by default).
  - div-by-0: o_done high in the cycle after edge 2.
- o_busy is 1 from edge 0 until the DONE state is entered.
- i_start while busy or in DONE is ignored, with no queuing. Changes on i_s1, i_s2, signs or func after edge 0 have no effect.
- Outputs o_result, o_sign and o_err change only in CHECK or on reset.
- Back-to-back operations: i_start in the first IDLE cycle after DONE is accepted.

Test Plan:
- Add, opposite signs: start with func=00, s1=25/+, s2=40/- -> o_done exactly 4 cycles after start edge; result 15, sign 1, err 0; busy high for 3 cycles.
- Multiply: func=10, s1=999/+, s2=1000/- -> o_done at edge+24; result 999000, sign 1, err 0. Then 1000x1000 -> result 0, err 1, sign 0.
- Divide: func=11, s1=7/+, s2=2/- -> result 3, sign 1. Then 0/5 with s1 negative -> result 0, sign 0. Then 12/0 -> err 1, result 0, done at edge+3.
- Subtract to zero: func=01, s1=500/+, s2=500/+ -> result 0, sign 0 (no negative zero); 999999+1 add -> err 1.
- Reset mid-multiply: assert i_reset 10 cycles after start -> next edge busy 0, state IDLE, all outputs 0, no o_done pulse afterwards.
- Start while busy: second i_start with different operands at edge+5 of a divide -> ignored; first result unchanged. A new start in the cycle after DONE is accepted, with busy rising on that edge.
